// File: rtl/toy_pkg.sv
// Shared widths and one-hot state indices for the toy loop
// controller and its datapath.
package toy_pkg;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;
   localparam int ACC_W_DEF  = 40;

   localparam int N_STATES = 5;
   localparam int S0_IDX   = 0;
   localparam int S1_IDX   = 1;
   localparam int S2_IDX   = 2;
   localparam int S3_IDX   = 3;
   localparam int S4_IDX   = 4;

   typedef logic [N_STATES-1:0] state_vec_t;
endpackage

// File: rtl/toy_mem_if.sv
// Memory request/response tracking for the issue and wait states,
// including the controller stall.
module toy_mem_if (
   input  logic clk,
   input  logic reset,
   input  logic s1,
   input  logic s2,
   input  logic mem_req_ready,
   input  logic mem_rsp_valid,
   output logic mem_req_valid,
   output logic fsm_stall,
   output logic rsp_fire,
   output logic rsp_stray
);
   logic req_done;
   logic req_fire;
   logic s1_stall;
   logic s2_stall;

   assign mem_req_valid = reset & s1 & ~req_done;
   assign req_fire      = mem_req_valid & mem_req_ready;
   assign rsp_fire      = s2 & req_done & mem_rsp_valid;
   assign rsp_stray     = mem_rsp_valid & ~rsp_fire;

   // Gated by reset so the controller never sees a stall in reset
   assign s1_stall  = s1 & ~req_done & ~mem_req_ready;
   assign s2_stall  = s2 & ~mem_rsp_valid;
   assign fsm_stall = reset & (s1_stall | s2_stall);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_done <= 1'b0;
      end else if (s2 && mem_rsp_valid) begin
         req_done <= 1'b0;
      end else if (req_fire) begin
         req_done <= 1'b1;
      end
   end
endmodule

// File: rtl/toy_loop_datapath.sv
// Loop datapath: reads one word per iteration, accumulates it,
// and returns the sum when the controller reaches the finish state.
module toy_loop_datapath
   import toy_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] trip_count,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              is_STATE_0,
   input  logic              is_STATE_1,
   input  logic              is_STATE_2,
   input  logic              is_STATE_3,
   input  logic              is_STATE_4,
   output logic              fsm_stall,
   output logic              BB_1_EXIT,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic [ACC_W-1:0]  return_val,
   output logic              return_valid,
   output logic              proto_err
);
   state_vec_t        st;
   logic [ADDR_W-1:0] trip_r;
   logic [ADDR_W-1:0] base_r;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_nxt;
   logic [ACC_W-1:0]  acc;
   logic              rsp_fire;
   logic              rsp_stray;

   assign st = {is_STATE_4, is_STATE_3, is_STATE_2,
                is_STATE_1, is_STATE_0};

   assign idx_nxt   = idx + ADDR_W'(1);
   assign mem_addr  = base_r + idx;
   assign BB_1_EXIT = st[S3_IDX] & (idx_nxt >= trip_r);

   toy_mem_if u_mem_if (
      .clk           (clk),
      .reset         (reset),
      .s1            (st[S1_IDX]),
      .s2            (st[S2_IDX]),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_req_valid (mem_req_valid),
      .fsm_stall     (fsm_stall),
      .rsp_fire      (rsp_fire),
      .rsp_stray     (rsp_stray)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trip_r <= '0;
         base_r <= '0;
         idx    <= '0;
         acc    <= '0;
      end else begin
         unique case (1'b1)
            st[S0_IDX]: begin
               if (start) begin
                  trip_r <= trip_count;
                  base_r <= base_addr;
                  idx    <= '0;
                  acc    <= '0;
               end
            end
            st[S2_IDX]: begin
               if (rsp_fire) acc <= acc + ACC_W'(mem_rsp_data);
            end
            st[S3_IDX]: idx <= idx_nxt;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         return_val   <= '0;
         return_valid <= 1'b0;
         proto_err    <= 1'b0;
      end else begin
         return_valid <= st[S4_IDX];
         if (st[S4_IDX]) return_val <= acc;
         // Stray responses are dropped but remembered
         if (rsp_stray) proto_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_toy_loop_datapath.sv
// Scoreboard bench: a controller model and memory model drive the
// datapath; monitors check addresses, exit flags and return values.
module tb_toy_loop_datapath;
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  trip_count;
   logic [7:0]  base_addr;
   logic        is_STATE_0, is_STATE_1, is_STATE_2;
   logic        is_STATE_3, is_STATE_4;
   logic        fsm_stall, BB_1_EXIT, mem_req_valid;
   logic        mem_req_ready;
   logic [7:0]  mem_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic [39:0] return_val;
   logic        return_valid, proto_err;
   logic        stall8, exit8, req_valid8, rv8, perr8;
   logic [7:0]  addr8;
   logic [7:0]  ret8;

   int          st;
   int          checks = 0;
   int          errors = 0;
   int          stall1, stall2;
   int          hold_cnt, rsp_lat, rsp_cd, rd_i;
   logic        ramp, inject;
   logic [31:0] words [4];

   logic [7:0]  addr_q [$];
   logic        exit_q [$];
   logic [39:0] ret_q [$];
   logic [7:0]  ret8_q [$];
   logic [7:0]  mon_a;
   logic [39:0] mon_r;
   logic [7:0]  mon_r8;

   always #5 clk = ~clk;

   toy_loop_datapath dut (
      .clk(clk), .reset(reset), .start(start),
      .trip_count(trip_count), .base_addr(base_addr),
      .is_STATE_0(is_STATE_0), .is_STATE_1(is_STATE_1),
      .is_STATE_2(is_STATE_2), .is_STATE_3(is_STATE_3),
      .is_STATE_4(is_STATE_4), .fsm_stall(fsm_stall),
      .BB_1_EXIT(BB_1_EXIT), .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .return_val(return_val), .return_valid(return_valid),
      .proto_err(proto_err)
   );

   toy_loop_datapath #(.DATA_W(8), .ADDR_W(8), .ACC_W(8)) dut8 (
      .clk(clk), .reset(reset), .start(start),
      .trip_count(trip_count), .base_addr(base_addr),
      .is_STATE_0(is_STATE_0), .is_STATE_1(is_STATE_1),
      .is_STATE_2(is_STATE_2), .is_STATE_3(is_STATE_3),
      .is_STATE_4(is_STATE_4), .fsm_stall(stall8),
      .BB_1_EXIT(exit8), .mem_req_valid(req_valid8),
      .mem_req_ready(mem_req_ready), .mem_addr(addr8),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data[7:0]),
      .return_val(ret8), .return_valid(rv8),
      .proto_err(perr8)
   );

   assign is_STATE_0 = (st == 0);
   assign is_STATE_1 = (st == 1);
   assign is_STATE_2 = (st == 2);
   assign is_STATE_3 = (st == 3);
   assign is_STATE_4 = (st == 4);

   always @(posedge clk or negedge reset) begin
      if (!reset) st <= 0;
      else begin
         case (st)
            0: if (start) st <= 1;
            1: if (!fsm_stall) st <= 2;
            2: if (!fsm_stall) st <= 3;
            3: st <= BB_1_EXIT ? 4 : 1;
            default: st <= 0;
         endcase
      end
   end

   always @(posedge clk) begin
      #1;
      if (!reset) begin
         mem_req_ready = 1'b0;
         mem_rsp_valid = 1'b0;
         rsp_cd = 0;
      end else begin
         mem_rsp_valid = 1'b0;
         if (rsp_cd != 0) begin
            rsp_cd--;
            if (rsp_cd == 0) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data = ramp ? 32'(rd_i + 1) : words[rd_i % 4];
               rd_i++;
            end
         end
         if (inject && is_STATE_3) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data = 32'hFF;
            inject = 1'b0;
         end
         mem_req_ready = 1'b0;
         if (mem_req_valid) begin
            if (hold_cnt > 0) hold_cnt--;
            else begin
               mem_req_ready = 1'b1;
               rsp_cd = rsp_lat;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: event with empty scoreboard", nm);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (is_STATE_1 && fsm_stall) begin
            stall1++;
            if (addr_q.size() > 0) chk("addr_hold", mem_addr, addr_q[0]);
         end
         if (is_STATE_2 && fsm_stall) stall2++;
         if (mem_req_valid && mem_req_ready) begin
            if (addr_q.size() == 0) unexpected("mem_addr");
            else begin
               mon_a = addr_q.pop_front();
               chk("mem_addr", mem_addr, mon_a);
               chk("mem_addr8", addr8, mon_a);
            end
         end
         if (is_STATE_3) begin
            if (exit_q.size() == 0) unexpected("exit");
            else chk("bb_1_exit", BB_1_EXIT, exit_q.pop_front());
         end
         if (return_valid) begin
            if (ret_q.size() == 0) unexpected("return_val");
            else begin
               mon_r = ret_q.pop_front();
               mon_r8 = ret8_q.pop_front();
               chk("return_val", return_val, mon_r);
               chk("return_val8", ret8, mon_r8);
            end
         end
      end
   end

   task automatic run(input logic [7:0] b, input logic [7:0] t,
                      input int n, input int hold, input int lat,
                      input logic [39:0] s40, input logic [7:0] s8,
                      input int ecyc, input int es1, input int es2);
      int cyc;
      for (int i = 0; i < n; i++) begin
         addr_q.push_back(b + 8'(i));
         exit_q.push_back(i == n - 1);
      end
      ret_q.push_back(s40);
      ret8_q.push_back(s8);
      hold_cnt = hold;
      rsp_lat = lat;
      rd_i = 0;
      stall1 = 0;
      stall2 = 0;
      @(negedge clk);
      trip_count = t;
      base_addr = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!return_valid && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk("latency", cyc, ecyc);
      chk("stall_s1", stall1, es1);
      chk("stall_s2", stall2, es2);
      @(negedge clk);
      chk("rv_pulse", return_valid, 0);
      chk("sb_empty", addr_q.size() + exit_q.size() + ret_q.size(), 0);
   endtask

   initial begin
      int cyc;
      reset = 1'b0;
      start = 1'b0;
      trip_count = '0;
      base_addr = '0;
      ramp = 1'b0;
      inject = 1'b0;
      hold_cnt = 0;
      rsp_lat = 1;
      rd_i = 0;
      mem_rsp_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_ret", return_val, 0);
      chk("rst_rv", {return_valid, rv8}, 0);
      chk("rst_perr", {proto_err, perr8}, 0);
      chk("rst_stall", {fsm_stall, stall8}, 0);
      chk("rst_reqv", {mem_req_valid, req_valid8}, 0);
      chk("rst_exit", {BB_1_EXIT, exit8}, 0);
      reset = 1'b1;

      words[0] = 5; words[1] = 7; words[2] = 9;
      run(8'h10, 8'd3, 3, 0, 1, 40'd21, 8'd21, 11, 0, 0);
      run(8'h10, 8'd3, 3, 4, 1, 40'd21, 8'd21, 15, 4, 0);
      words[0] = 32'h11;
      run(8'h20, 8'd1, 1, 0, 6, 40'h11, 8'h11, 10, 0, 5);
      words[0] = 32'hDEADBEEF;
      run(8'hFE, 8'd0, 1, 0, 1, 40'hDEADBEEF, 8'hEF, 5, 0, 0);
      words[0] = 200; words[1] = 100;
      run(8'hFF, 8'd2, 2, 0, 1, 40'd300, 8'd44, 8, 0, 0);
      ramp = 1'b1;
      run(8'h00, 8'd255, 255, 0, 1, 40'd32640, 8'h80, 767, 0, 0);
      ramp = 1'b0;

      chk("perr_clean", proto_err, 0);
      words[0] = 1; words[1] = 2;
      inject = 1'b1;
      run(8'h40, 8'd2, 2, 0, 1, 40'd3, 8'd3, 8, 0, 0);
      chk("perr_set", {proto_err, perr8}, 2'b11);

      words[0] = 32'h100; words[1] = 32'h200;
      addr_q.push_back(8'h50);
      rsp_lat = 6;
      hold_cnt = 0;
      rd_i = 0;
      @(negedge clk);
      trip_count = 8'd2;
      base_addr = 8'h50;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!is_STATE_2 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("reach_s2", is_STATE_2, 1);
      chk("s2_stall", fsm_stall, 1);
      reset = 1'b0;
      #1;
      chk("mid_stall", fsm_stall, 0);
      chk("mid_reqv", mem_req_valid, 0);
      chk("mid_exit", BB_1_EXIT, 0);
      chk("mid_ret", {return_val, return_valid}, 0);
      chk("mid_perr", {proto_err, perr8}, 0);
      addr_q.delete();
      exit_q.delete();
      ret_q.delete();
      ret8_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      words[0] = 3; words[1] = 4;
      run(8'h60, 8'd2, 2, 0, 1, 40'd7, 8'd7, 8, 0, 0);
      chk("perr_after", {proto_err, perr8}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/toy_loop_datapath.md
Name: toy_loop_datapath

Overview:
- Datapath stage directly downstream of the toy loop controller FSM.
- Consumes the controller's one-hot state strobes and produces the two signals the FSM needs: BB_1_EXIT (loop exit condition) and fsm_stall (resource stall).
- Loop body: read one word per iteration from a memory port and accumulate it; on exit, present the sum as the function return value.

Parameters:
- DATA_W, 32, memory read data width.
- ADDR_W, 8, address and iteration-counter width.
- ACC_W, 40, accumulator and return value width; must be >= DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- start  in  1  host start; sampled only while is_STATE_0=1.
- trip_count  in  ADDR_W  iteration count; latched with start.
- base_addr  in  ADDR_W  first word address; latched with start.
- is_STATE_0 .. is_STATE_4  in  1 each  one-hot state strobes from the controller.
- fsm_stall  out  1  stalls the controller while the memory is busy.
- BB_1_EXIT  out  1  loop exit condition, valid in STATE_3.
- mem_req_valid  out  1  read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_W  read address.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  DATA_W  read data.
- return_val  out  ACC_W  final sum.
- return_valid  out  1  one-cycle pulse when return_val updates.
- proto_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (reset=0, async): trip_r, base_r, idx, acc, return_val, req_done, return_valid and proto_err are all cleared to 0.
  - Combinational outputs while in reset: fsm_stall=0, mem_req_valid=0.
- STATE_0:
  - If start=1, trip_r<=trip_count, base_r<=base_addr, idx<=0, acc<=0.
  - Otherwise all registers hold. start is ignored in every other state.
- STATE_1 (issue request):
  - mem_req_valid=!req_done.
  - mem_addr=base_r+idx, modulo 2^ADDR_W.
  - fsm_stall=!req_done && !mem_req_ready. The handshake cycle itself does not stall.
  - On handshake (valid&ready): req_done<=1. req_done clears on leaving STATE_2.
- STATE_2 (wait for response):
  - fsm_stall=!mem_rsp_valid.
  - On mem_rsp_valid: acc<=acc+zero_extend(mem_rsp_data), modulo 2^ACC_W.
  - Minimum memory latency is 1 cycle, so the earliest STATE_1→STATE_2 path costs 2 cycles.
- STATE_3 (increment and test): fsm_stall=0.
  - BB_1_EXIT=((idx+1) mod 2^ADDR_W) >= trip_r; combinational, ADDR_W-bit unsigned compare.
  - idx<=idx+1 at the end of STATE_3.
  - BB_1_EXIT is driven to 0 outside STATE_3.
- STATE_4:
  - return_val<=acc, return_valid<=1 for exactly one cycle; this coincides with the controller's finish pulse.
  - fsm_stall=0.
- fsm_stall is asserted only in STATE_1 and STATE_2, as defined above.
- Boundary rules:
  - trip_count=0: loop has do-while semantics; exactly one word is read (exit tested after the first body).
  - trip_count=2^ADDR_W-1: 2^ADDR_W-1 iterations. The count of 2^ADDR_W is unreachable.
  - mem_rsp_valid outside STATE_2, or during STATE_2 before a request handshake: proto_err<=1 (sticky until reset) and the data is discarded.
  - Accumulator overflow wraps silently.
  - Reset mid-loop: all state clears asynchronously. The controller shares the same reset net and returns to STATE_0. An outstanding memory response after reset trips proto_err only if it arrives in STATE_0..STATE_1; integration must flush the memory on reset.
- Latency: with zero-wait memory (ready=1, rsp 1 cycle later), one iteration takes 3 cycles (S1,S2,S3). Start to return_valid is 3N+2 cycles.

Decomposition:
- Shared package toy_pkg:
  - ADDR_W/DATA_W/ACC_W defaults.
  - One-hot state index constants (S0_IDX..S4_IDX) used by both controller and datapath.
- One natural sub-module: toy_mem_if. It holds the req_done flag and the stall/request logic for STATE_1/STATE_2 and exposes rsp_fire.
- Counter, accumulator and return registers stay in the top.

Test Plan:
- Sum, zero-wait memory: base=0x10, trip=3, memory returns 5,7,9 → BB_1_EXIT=1 on the 3rd STATE_3 only; return_val=21, return_valid pulses once at cycle 11 after start.
- Request backpressure: mem_req_ready low for 4 cycles in the first STATE_1 → fsm_stall=1 for exactly 4 cycles; mem_addr holds 0x10; final sum unchanged.
- Response delay: rsp arrives 6 cycles after handshake → fsm_stall high 5 cycles in STATE_2; acc updates only on the rsp cycle.
- trip_count=0: one read at base_addr, BB_1_EXIT=1 on the first STATE_3, return_val equals that word.
- Accumulator wrap with ACC_W=DATA_W=8: data 200,100 → return_val=44.
- Errors and reset: a stray mem_rsp_valid in STATE_3 sets proto_err and acc is unchanged. Pulling reset low mid-STATE_2 clears all outputs within the same cycle. A subsequent start runs cleanly with proto_err=0.
